// File: rtl/verifica_senha_if.sv
// Keypad/password handshake between the main access FSM and verifica_senha.
// The master side drives entry enable and key strobes; the slave returns verdict levels.
interface verifica_senha_if;
  logic       IN_PASW;
  logic       key_valid;
  logic [3:0] key_code;
  logic       IN;
  logic       ERRO;
  logic       OK;
  logic [2:0] dig_cnt;

  modport master (
    output IN_PASW, key_valid, key_code,
    input  IN, ERRO, OK, dig_cnt
  );

  modport slave (
    input  IN_PASW, key_valid, key_code,
    output IN, ERRO, OK, dig_cnt
  );
endinterface

// File: rtl/verifica_senha.sv
// 4-digit BCD keypad password checker with inter-key timeout (IN pulse on expiry).
// Defining SENHA_BLOQUEIO_EN adds the consecutive-failure counter and the LOCK state.
module verifica_senha #(
  parameter logic [15:0] SENHA       = 16'h1234,
  parameter int unsigned TIMEOUT_CYC = 1000
`ifdef SENHA_BLOQUEIO_EN
  ,
  parameter int unsigned MAX_TENT    = 3,
  parameter int unsigned LOCK_CYC    = 5000
`endif
) (
  input  logic            clk,
  input  logic            rst,
  verifica_senha_if.slave bus
);

  localparam int TW = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 32'd1);
`ifdef SENHA_BLOQUEIO_EN
  localparam int FW = $clog2(MAX_TENT + 32'd1);
  localparam int LW = (LOCK_CYC > 32'd1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_TENT - 32'd1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 32'd1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RES_OK  = 3'd3,
    ST_RES_ERR = 3'd4
`ifdef SENHA_BLOQUEIO_EN
    ,
    ST_LOCK    = 3'd5
`endif
  } state_t;

  state_t        state_r, state_s;
  logic [15:0]   buf_r, buf_s;
  logic [2:0]    cnt_r, cnt_s;
  logic [TW-1:0] timer_r, timer_s;
  logic          pasw_d_r;
  logic          in_r, in_s;
  logic          erro_r, erro_s;
  logic          ok_r, ok_s;
`ifdef SENHA_BLOQUEIO_EN
  logic [FW-1:0] fail_r, fail_s;
  logic [LW-1:0] lock_r, lock_s;
`endif

  logic key_digit_s;
  logic key_clear_s;
  logic pasw_rise_s;

  assign key_digit_s = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_clear_s = bus.key_valid && (bus.key_code == 4'hA);
  assign pasw_rise_s = bus.IN_PASW && !pasw_d_r;

  assign bus.IN      = in_r;
  assign bus.ERRO    = erro_r;
  assign bus.OK      = ok_r;
  assign bus.dig_cnt = cnt_r;

  // Next-state, datapath and output decode
  always_comb begin
    state_s = state_r;
    buf_s   = buf_r;
    cnt_s   = cnt_r;
    timer_s = timer_r;
    in_s    = 1'b0;
`ifdef SENHA_BLOQUEIO_EN
    fail_s  = fail_r;
    lock_s  = lock_r;
`endif
    case (state_r)
      ST_IDLE: begin
        buf_s   = 16'h0000;
        cnt_s   = 3'd0;
        timer_s = {TW{1'b0}};
        if (pasw_rise_s) begin
          state_s = ST_ENTRY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        // Losing IN_PASW outranks a 4th digit or a timer expiry in the same cycle
        if (!bus.IN_PASW) begin
          state_s = ST_IDLE;
          buf_s   = 16'h0000;
          cnt_s   = 3'd0;
          timer_s = {TW{1'b0}};
        end else if (key_digit_s) begin
          buf_s   = {buf_r[11:0], bus.key_code};
          cnt_s   = cnt_r + 3'd1;
          timer_s = {TW{1'b0}};
          if (cnt_r == 3'd3) begin
            state_s = ST_CHECK;
          end else begin
            state_s = ST_ENTRY;
          end
        end else if (key_clear_s) begin
          buf_s   = 16'h0000;
          cnt_s   = 3'd0;
          timer_s = {TW{1'b0}};
        end else if (timer_r == TIMER_LAST) begin
          state_s = ST_IDLE;
          buf_s   = 16'h0000;
          cnt_s   = 3'd0;
          timer_s = {TW{1'b0}};
          in_s    = 1'b1;
        end else begin
          timer_s = timer_r + TW'(1'b1);
        end
      end
      ST_CHECK: begin
        if (!bus.IN_PASW) begin
          state_s = ST_IDLE;
          buf_s   = 16'h0000;
          cnt_s   = 3'd0;
        end else if (buf_r == SENHA) begin
          state_s = ST_RES_OK;
`ifdef SENHA_BLOQUEIO_EN
          fail_s  = {FW{1'b0}};
`endif
        end else begin
`ifdef SENHA_BLOQUEIO_EN
          fail_s = fail_r + FW'(1'b1);
          if (fail_r >= FAIL_LAST) begin
            state_s = ST_LOCK;
            lock_s  = {LW{1'b0}};
            buf_s   = 16'h0000;
            cnt_s   = 3'd0;
          end else begin
            state_s = ST_RES_ERR;
          end
`else
          state_s = ST_RES_ERR;
`endif
        end
      end
      ST_RES_OK: begin
        if (!bus.IN_PASW) begin
          state_s = ST_IDLE;
          buf_s   = 16'h0000;
          cnt_s   = 3'd0;
        end else begin
          state_s = ST_RES_OK;
        end
      end
      ST_RES_ERR: begin
        // A digit here is the first digit of the next attempt
        if (!bus.IN_PASW) begin
          state_s = ST_IDLE;
          buf_s   = 16'h0000;
          cnt_s   = 3'd0;
        end else if (key_digit_s) begin
          state_s = ST_ENTRY;
          buf_s   = {12'h000, bus.key_code};
          cnt_s   = 3'd1;
          timer_s = {TW{1'b0}};
        end else begin
          state_s = ST_RES_ERR;
        end
      end
`ifdef SENHA_BLOQUEIO_EN
      ST_LOCK: begin
        buf_s = 16'h0000;
        cnt_s = 3'd0;
        if (lock_r == LOCK_LAST) begin
          state_s = ST_IDLE;
          fail_s  = {FW{1'b0}};
          lock_s  = {LW{1'b0}};
        end else begin
          state_s = ST_LOCK;
          lock_s  = lock_r + LW'(1'b1);
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
        buf_s   = 16'h0000;
        cnt_s   = 3'd0;
        timer_s = {TW{1'b0}};
      end
    endcase

    ok_s = (state_s == ST_RES_OK);
`ifdef SENHA_BLOQUEIO_EN
    erro_s = (state_s == ST_RES_ERR) || (state_s == ST_LOCK);
`else
    erro_s = (state_s == ST_RES_ERR);
`endif
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      buf_r    <= 16'h0000;
      cnt_r    <= 3'd0;
      timer_r  <= {TW{1'b0}};
      pasw_d_r <= 1'b0;
      in_r     <= 1'b0;
      erro_r   <= 1'b0;
      ok_r     <= 1'b0;
`ifdef SENHA_BLOQUEIO_EN
      fail_r   <= {FW{1'b0}};
      lock_r   <= {LW{1'b0}};
`endif
    end else begin
      state_r  <= state_s;
      buf_r    <= buf_s;
      cnt_r    <= cnt_s;
      timer_r  <= timer_s;
      pasw_d_r <= bus.IN_PASW;
      in_r     <= in_s;
      erro_r   <= erro_s;
      ok_r     <= ok_s;
`ifdef SENHA_BLOQUEIO_EN
      fail_r   <= fail_s;
      lock_r   <= lock_s;
`endif
    end
  end

endmodule

// File: tb/tb_verifica_senha.sv
// Self-checking bench for verifica_senha: directed scenarios plus randomized code entry,
// with expected verdicts and timing derived from the password rules (TIMEOUT_CYC=20, LOCK_CYC=50).
module tb_verifica_senha;
  localparam logic [15:0] PASS = 16'h1234;
  localparam int TMO = 20;
`ifdef SENHA_BLOQUEIO_EN
  localparam int LCK = 50;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   fails = 0;
  bit   lk;
  logic [15:0] code;
  int   hold;

  verifica_senha_if bus ();

  always #5 clk = ~clk;

  verifica_senha #(
    .SENHA(PASS),
    .TIMEOUT_CYC(TMO)
`ifdef SENHA_BLOQUEIO_EN
    ,
    .MAX_TENT(3),
    .LOCK_CYC(LCK)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic in_e, input logic erro_e,
                         input logic ok_e, input logic [2:0] cnt_e);
    chk({tag, ".IN"}, bus.IN, in_e);
    chk({tag, ".ERRO"}, bus.ERRO, erro_e);
    chk({tag, ".OK"}, bus.OK, ok_e);
    chk({tag, ".dig_cnt"}, bus.dig_cnt, cnt_e);
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    cyc();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic open_session();
    bus.IN_PASW = 1'b0;
    cyc();
    bus.IN_PASW = 1'b1;
    cyc();
  endtask

  task automatic close_session(input string tag);
    bus.IN_PASW = 1'b0;
    cyc();
    chk_all(tag, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // idle cycles (some with ignored keys B-F), always shorter than the timeout
  task automatic idle_gap(input int cnt_e);
    int g;
    g = ($urandom_range(0, 7) == 7) ? TMO - 1 : int'($urandom_range(0, 5));
    for (int k = 0; k < g; k++) begin
      if ($urandom_range(0, 3) == 0) press(4'($urandom_range(11, 15)));
      else cyc();
    end
    chk("gap.dig_cnt", bus.dig_cnt, cnt_e);
    chk("gap.IN", bus.IN, 1'b0);
  endtask

  task automatic enter_code(input logic [15:0] c, input bit rnd_gap);
    for (int i = 0; i < 4; i++) begin
      press(c[15 - 4*i -: 4]);
      chk("entry.dig_cnt", bus.dig_cnt, i + 1);
      if (rnd_gap && i < 3) idle_gap(i + 1);
    end
  endtask

`ifdef SENHA_BLOQUEIO_EN
  task automatic wait_lock();
    for (int k = 1; k < LCK; k++) begin
      if (k == 10) bus.IN_PASW = ~bus.IN_PASW;
      if (k < 5) press(4'(k));
      else cyc();
      chk("lock.ERRO", bus.ERRO, 1'b1);
      chk("lock.OK", bus.OK, 1'b0);
    end
    cyc();
    chk("lock.release.ERRO", bus.ERRO, 1'b0);
    chk("lock.release.dig_cnt", bus.dig_cnt, 3'd0);
    fails = 0;
  endtask
`endif

  // called right after the 4th digit: one CHECK cycle, then the verdict
  task automatic verdict(input logic [15:0] c, output bit locked);
    bit exp_ok;
    exp_ok = (c == PASS);
    chk_all("check", 1'b0, 1'b0, 1'b0, 3'd4);
    cyc();
    chk("verdict.OK", bus.OK, exp_ok);
    chk("verdict.ERRO", bus.ERRO, !exp_ok);
    chk("verdict.IN", bus.IN, 1'b0);
    if (exp_ok) fails = 0;
    else fails++;
    locked = 1'b0;
`ifdef SENHA_BLOQUEIO_EN
    if (fails >= 3) begin
      locked = 1'b1;
      wait_lock();
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.IN_PASW   = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    cyc();
    cyc();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    cyc();
    chk_all("post_reset", 1'b0, 1'b0, 1'b0, 3'd0);

    // correct code, OK held until IN_PASW falls
    open_session();
    chk_all("entry_start", 1'b0, 1'b0, 1'b0, 3'd0);
    enter_code(PASS, 1'b0);
    verdict(PASS, lk);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("ok_hold.OK", bus.OK, 1'b1);
      chk("ok_hold.ERRO", bus.ERRO, 1'b0);
    end
    press(4'h5);
    chk("ok_ignores_key.OK", bus.OK, 1'b1);
    close_session("ok_close");

    // wrong code, then retry from RES_ERR
    open_session();
    enter_code(16'h1235, 1'b0);
    verdict(16'h1235, lk);
    cyc();
    chk("err_hold.ERRO", bus.ERRO, 1'b1);
    press(4'h1);
    chk_all("retry_first", 1'b0, 1'b0, 1'b0, 3'd1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    verdict(PASS, lk);
    close_session("retry_close");

    // timeout after two digits
    open_session();
    press(4'h1);
    press(4'h2);
    for (int k = 1; k < TMO; k++) begin
      cyc();
      chk("tmo_wait.IN", bus.IN, 1'b0);
      chk("tmo_wait.dig_cnt", bus.dig_cnt, 3'd2);
    end
    cyc();
    chk_all("tmo_pulse", 1'b1, 1'b0, 1'b0, 3'd0);
    cyc();
    chk("tmo_pulse_end.IN", bus.IN, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) press(4'h1);
      else cyc();
      chk_all("tmo_no_reentry", 1'b0, 1'b0, 1'b0, 3'd0);
    end
    close_session("tmo_close");

    // IN_PASW fall coinciding with timer expiry: no IN pulse
    open_session();
    press(4'h7);
    for (int k = 1; k < TMO; k++) cyc();
    bus.IN_PASW = 1'b0;
    cyc();
    chk_all("fall_vs_tmo", 1'b0, 1'b0, 1'b0, 3'd0);
    cyc();
    chk("fall_vs_tmo_next.IN", bus.IN, 1'b0);

    // clear key, ignored key, clear restarting the timer
    open_session();
    press(4'h9);
    press(4'h9);
    chk("clr_pre.dig_cnt", bus.dig_cnt, 3'd2);
    press(4'hA);
    chk("clr.dig_cnt", bus.dig_cnt, 3'd0);
    for (int k = 1; k < TMO; k++) cyc();
    chk("clr_timer.IN", bus.IN, 1'b0);
    press(4'h1);
    press(4'hF);
    chk("ignored_F.dig_cnt", bus.dig_cnt, 3'd1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    verdict(PASS, lk);
    close_session("clr_close");

    // IN_PASW fall together with the 4th correct digit
    open_session();
    press(4'h1);
    press(4'h2);
    press(4'h3);
    bus.IN_PASW = 1'b0;
    press(4'h4);
    chk_all("fall_vs_4th", 1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("fall_vs_4th_after.OK", bus.OK, 1'b0);
    end

    // reset mid-entry discards progress
    open_session();
    press(4'h1);
    press(4'h2);
    #2 rst = 1'b1;
    bus.IN_PASW = 1'b0;
    #1 chk_all("rst_mid_entry", 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    cyc();
    open_session();
    enter_code(PASS, 1'b0);
    verdict(PASS, lk);
    close_session("rst_entry_close");

    // randomized codes and key timing
    for (int t = 0; t < 12; t++) begin
      code = 16'h0000;
      for (int i = 0; i < 4; i++) code = {code[11:0], 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 2) == 0) code = PASS;
      open_session();
      enter_code(code, 1'b1);
      verdict(code, lk);
      if (!lk) begin
        hold = $urandom_range(1, 3);
        for (int k = 0; k < hold; k++) begin
          cyc();
          chk("rnd_hold.OK", bus.OK, code == PASS);
          chk("rnd_hold.ERRO", bus.ERRO, code != PASS);
        end
      end
      close_session("rnd_close");
    end

    // consecutive wrong codes: unlimited retries, or lockout when compiled in
    open_session();
    enter_code(PASS, 1'b0);
    verdict(PASS, lk);
    close_session("pre_retry_close");
    open_session();
    for (int n = 0; n < 4; n++) begin
      enter_code(16'h4321, 1'b0);
      verdict(16'h4321, lk);
      if (lk) open_session();
    end
    enter_code(PASS, 1'b0);
    verdict(PASS, lk);
    close_session("retry_loop_close");

`ifdef SENHA_BLOQUEIO_EN
    // reset during LOCK discards the lockout and the failure count
    open_session();
    enter_code(16'h0000, 1'b0);
    verdict(16'h0000, lk);
    enter_code(16'h0000, 1'b0);
    verdict(16'h0000, lk);
    enter_code(16'h0000, 1'b0);
    cyc();
    chk("lock_enter.ERRO", bus.ERRO, 1'b1);
    for (int k = 0; k < 10; k++) cyc();
    chk("lock_mid.ERRO", bus.ERRO, 1'b1);
    #2 rst = 1'b1;
    bus.IN_PASW = 1'b0;
    #1 chk_all("rst_in_lock", 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    fails = 0;
    cyc();
    open_session();
    enter_code(16'h9999, 1'b0);
    verdict(16'h9999, lk);
    enter_code(PASS, 1'b0);
    verdict(PASS, lk);
    close_session("rst_lock_close");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
